// File: rtl/ex_stage_mul.sv
// Execute stage + EX/MEM register: forwarding muxes, single-cycle ALU, optional iterative multiplier (define MUL_EN).
// Latency: ALU ops 1 cycle; mul (MUL_EN) writes EX/MEM N+1 cycles after issue, N = 32/MUL_BITS_PER_CYCLE.
// Backpressure: stall_o holds PC, IF/ID and ID/EX while a multiply is in flight; flush_i kills EX and aborts it.
module ex_stage_mul #(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] RSdata_i,
    input  logic [31:0] RTdata_i,
    input  logic [4:0]  RSaddr_i,
    input  logic [4:0]  RTaddr_i,
    input  logic [4:0]  RDaddr_i,
    input  logic [31:0] immed_i,
    input  logic        ALUSrc_i,
    input  logic        MemToReg_i,
    input  logic        RegWrite_i,
    input  logic        MemWrite_i,
    input  logic        MemRead_i,
    input  logic [1:0]  ALUOp_i,
    input  logic [4:0]  MEMWB_RDaddr_i,
    input  logic        MEMWB_RegWrite_i,
    input  logic [31:0] MEMWB_data_i,
    output logic        stall_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] RTdata_o,
    output logic [4:0]  RDaddr_o,
    output logic        MemToReg_o,
    output logic        RegWrite_o,
    output logic        MemWrite_o,
    output logic        MemRead_o
);

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [5:0] F_MUL = 6'h18;

    logic [31:0] fwd_a, fwd_b, op_b, alu_res;
    logic        mul_op;
    logic [5:0]  funct;

    logic [31:0] nx_res, nx_rt;
    logic [4:0]  nx_rd;
    logic        nx_m2r, nx_rw, nx_mw, nx_mr;

    assign funct = immed_i[5:0];

    // EX/MEM beats MEM/WB; register 0 is never forwarded
    always_comb begin
        fwd_a = RSdata_i;
        if (RegWrite_o && RDaddr_o != 5'd0 && RDaddr_o == RSaddr_i)
            fwd_a = ALUResult_o;
        else if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == RSaddr_i)
            fwd_a = MEMWB_data_i;
    end

    always_comb begin
        fwd_b = RTdata_i;
        if (RegWrite_o && RDaddr_o != 5'd0 && RDaddr_o == RTaddr_i)
            fwd_b = ALUResult_o;
        else if (MEMWB_RegWrite_i && MEMWB_RDaddr_i != 5'd0 && MEMWB_RDaddr_i == RTaddr_i)
            fwd_b = MEMWB_data_i;
    end

    assign op_b = ALUSrc_i ? immed_i : fwd_b;

    always_comb begin
        alu_res = 32'd0;
        mul_op  = 1'b0;
        case (ALUOp_i)
            2'b00: alu_res = fwd_a + op_b;
            2'b01: alu_res = fwd_a - op_b;
            2'b11: alu_res = fwd_a | op_b;
            default: begin
                case (funct)
                    F_ADD:   alu_res = fwd_a + op_b;
                    F_SUB:   alu_res = fwd_a - op_b;
                    F_AND:   alu_res = fwd_a & op_b;
                    F_OR:    alu_res = fwd_a | op_b;
                    F_SLT:   alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
                    F_MUL:   mul_op  = 1'b1;
                    default: alu_res = 32'd0;
                endcase
            end
        endcase
    end

`ifdef MUL_EN
    localparam int N = 32 / MUL_BITS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [31:0] mcand_q, mplier_q, acc_q, rt_q, pp;
    logic [4:0]  rd_q;
    logic        m2r_q, rw_q, mw_q, mr_q;
    logic        mul_start;

    assign mul_start = (state_q == IDLE) && mul_op && !flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (mul_op) state_d = BUSY;
                BUSY:    if (cnt_q == 6'd1) state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = (state_q == BUSY) || mul_start;
    end

    // One shift-add step retires MUL_BITS_PER_CYCLE multiplier bits
    always_comb begin
        pp = 32'd0;
        for (int i = 0; i < MUL_BITS_PER_CYCLE; i++)
            if (mplier_q[i]) pp = pp + (mcand_q << i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q    <= 6'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 32'd0;
            rt_q     <= 32'd0;
            rd_q     <= 5'd0;
            m2r_q    <= 1'b0;
            rw_q     <= 1'b0;
            mw_q     <= 1'b0;
            mr_q     <= 1'b0;
        end else if (mul_start) begin
            cnt_q    <= 6'(N);
            mcand_q  <= fwd_a;
            mplier_q <= op_b;
            acc_q    <= 32'd0;
            rt_q     <= fwd_b;
            rd_q     <= RDaddr_i;
            m2r_q    <= MemToReg_i;
            rw_q     <= RegWrite_i;
            mw_q     <= MemWrite_i;
            mr_q     <= MemRead_i;
        end else if (state_q == BUSY && !flush_i) begin
            acc_q    <= acc_q + pp;
            mcand_q  <= mcand_q << MUL_BITS_PER_CYCLE;
            mplier_q <= mplier_q >> MUL_BITS_PER_CYCLE;
            cnt_q    <= cnt_q - 6'd1;
        end
    end
`else
    assign stall_o = 1'b0;
`endif

    always_comb begin
        nx_res = 32'd0;
        nx_rt  = 32'd0;
        nx_rd  = 5'd0;
        nx_m2r = 1'b0;
        nx_rw  = 1'b0;
        nx_mw  = 1'b0;
        nx_mr  = 1'b0;
`ifdef MUL_EN
        if (!flush_i) begin
            if (state_q == IDLE && !mul_op) begin
                nx_res = alu_res;
                nx_rt  = fwd_b;
                nx_rd  = RDaddr_i;
                nx_m2r = MemToReg_i;
                nx_rw  = RegWrite_i;
                nx_mw  = MemWrite_i;
                nx_mr  = MemRead_i;
            end else if (state_q == DONE) begin
                nx_res = acc_q;
                nx_rt  = rt_q;
                nx_rd  = rd_q;
                nx_m2r = m2r_q;
                nx_rw  = rw_q;
                nx_mw  = mw_q;
                nx_mr  = mr_q;
            end
        end
`else
        // Without the multiplier, funct 0x18 is illegal and must not write back
        if (!flush_i) begin
            nx_res = alu_res;
            nx_rt  = fwd_b;
            nx_rd  = RDaddr_i;
            nx_m2r = MemToReg_i;
            nx_rw  = RegWrite_i & ~mul_op;
            nx_mw  = MemWrite_i;
            nx_mr  = MemRead_i;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ALUResult_o <= 32'd0;
            RTdata_o    <= 32'd0;
            RDaddr_o    <= 5'd0;
            MemToReg_o  <= 1'b0;
            RegWrite_o  <= 1'b0;
            MemWrite_o  <= 1'b0;
            MemRead_o   <= 1'b0;
        end else begin
            ALUResult_o <= nx_res;
            RTdata_o    <= nx_rt;
            RDaddr_o    <= nx_rd;
            MemToReg_o  <= nx_m2r;
            RegWrite_o  <= nx_rw;
            MemWrite_o  <= nx_mw;
            MemRead_o   <= nx_mr;
        end
    end

endmodule

// File: tb/tb_ex_stage_mul.sv
// Bench for ex_stage_mul: directed vectors; writebacks are checked against a queue of expected EX/MEM records.
module tb_ex_stage_mul;

    localparam int BPC = 1;

    logic        clk_i, rst_i, flush_i;
    logic [31:0] RSdata_i, RTdata_i, immed_i, MEMWB_data_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i, MEMWB_RDaddr_i;
    logic        ALUSrc_i, MemToReg_i, RegWrite_i, MemWrite_i, MemRead_i, MEMWB_RegWrite_i;
    logic [1:0]  ALUOp_i;
    logic        stall_o;
    logic [31:0] ALUResult_o, RTdata_o;
    logic [4:0]  RDaddr_o;
    logic        MemToReg_o, RegWrite_o, MemWrite_o, MemRead_o;

    ex_stage_mul #(.MUL_BITS_PER_CYCLE(BPC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .immed_i(immed_i), .ALUSrc_i(ALUSrc_i), .MemToReg_i(MemToReg_i),
        .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
        .ALUOp_i(ALUOp_i),
        .MEMWB_RDaddr_i(MEMWB_RDaddr_i), .MEMWB_RegWrite_i(MEMWB_RegWrite_i),
        .MEMWB_data_i(MEMWB_data_i),
        .stall_o(stall_o), .ALUResult_o(ALUResult_o), .RTdata_o(RTdata_o),
        .RDaddr_o(RDaddr_o), .MemToReg_o(MemToReg_o), .RegWrite_o(RegWrite_o),
        .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic [3:0]  ctl;  // {MemToReg, RegWrite, MemWrite, MemRead}
    } rec_t;

    rec_t exp_q[$];
    rec_t mon_act, mon_exp;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every non-bubble EX/MEM entry must match the oldest expected record
    always @(negedge clk_i) begin
        if (rst_i && (RegWrite_o || MemWrite_o || MemRead_o)) begin
            mon_act = '{res: ALUResult_o, rt: RTdata_o, rd: RDaddr_o,
                        ctl: {MemToReg_o, RegWrite_o, MemWrite_o, MemRead_o}};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got res=0x%08h rd=%0d ctl=%b, expected no writeback",
                         mon_act.res, mon_act.rd, mon_act.ctl);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL wb_record: got res=0x%08h rt=0x%08h rd=%0d ctl=%b, expected res=0x%08h rt=0x%08h rd=%0d ctl=%b",
                             mon_act.res, mon_act.rt, mon_act.rd, mon_act.ctl,
                             mon_exp.res, mon_exp.rt, mon_exp.rd, mon_exp.ctl);
                end
            end
        end
    end

    task automatic push(input logic [31:0] res, input logic [31:0] rt, input logic [4:0] rd,
                        input logic [3:0] ctl);
        exp_q.push_back('{res: res, rt: rt, rd: rd, ctl: ctl});
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                          input logic [31:0] rtd, input logic [4:0] rd, input logic [31:0] imm,
                          input logic alusrc, input logic [1:0] aluop, input logic [3:0] ctl);
        RSaddr_i = rs;  RSdata_i = rsd;
        RTaddr_i = rt;  RTdata_i = rtd;
        RDaddr_i = rd;  immed_i  = imm;
        ALUSrc_i = alusrc; ALUOp_i = aluop;
        {MemToReg_i, RegWrite_i, MemWrite_i, MemRead_i} = ctl;
    endtask

    task automatic rtype(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                         input logic [31:0] rtd, input logic [4:0] rd, input logic [5:0] funct);
        set_in(rs, rsd, rt, rtd, rd, {26'd0, funct}, 1'b0, 2'b10, 4'b0100);
    endtask

    task automatic nop();
        set_in(5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 2'b00, 4'b0000);
    endtask

    task automatic memwb(input logic [4:0] rd, input logic rw, input logic [31:0] d);
        MEMWB_RDaddr_i = rd; MEMWB_RegWrite_i = rw; MEMWB_data_i = d;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // ALU vector on registers 11/12 -> 13, so no forwarding path is hit
    task automatic alu_vec(input logic [1:0] op, input logic [5:0] funct, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        set_in(5'd11, a, 5'd12, b, 5'd13, {26'd0, funct}, 1'b0, op, 4'b0100);
        push(exp, b, 5'd13, 4'b0100);
        step();
    endtask

`ifdef MUL_EN
    // Issue a mul and hold it while stalled; returns the number of stalled cycles
    task automatic mul_run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                           input logic disturb, output int stall_cnt);
        stall_cnt = 0;
        rtype(5'd14, a, 5'd15, b, 5'd16, 6'h18);
        push(exp, b, 5'd16, 4'b0100);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (!stall_o) break;
            stall_cnt++;
            @(posedge clk_i);
            #1;
            if (disturb) memwb(5'd14, 1'b1, 32'd5);
        end
        step();
        nop();
        memwb(5'd0, 1'b0, 32'd0);
        step();
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MUL_EN
        int sc;
`endif
        rst_i = 1'b1;
        flush_i = 1'b0;
        nop();
        memwb(5'd0, 1'b0, 32'd0);
        #1 rst_i = 1'b0;
        #2;
        check("reset_result", ALUResult_o, 32'd0);
        check("reset_regwrite", {31'd0, RegWrite_o}, 32'd0);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        step();
        rst_i = 1'b1;

        // Mid-run reset clears EX/MEM immediately
        rtype(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 6'h20);
        step();
        check("pre_reset_result", ALUResult_o, 32'd12);
        nop();
        #1 rst_i = 1'b0;
        #1;
        check("midrun_reset_result", ALUResult_o, 32'd0);
        check("midrun_reset_ctl", {28'd0, MemToReg_o, RegWrite_o, MemWrite_o, MemRead_o}, 32'd0);
        step();
        rst_i = 1'b1;
        step();

        rtype(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 6'h20);
        push(32'd12, 32'd7, 5'd3, 4'b0100);
        step();
        check("add_one_edge", ALUResult_o, 32'd12);

        // EX/MEM forward of $3 into the dependent sub
        rtype(5'd3, 32'd0, 5'd1, 32'd5, 5'd4, 6'h22);
        push(32'd7, 32'd5, 5'd4, 4'b0100);
        step();
        nop();
        step();

        // MEM/WB-only forward, or-immediate and store data
        memwb(5'd5, 1'b1, 32'd100);
        set_in(5'd5, 32'd0, 5'd0, 32'd0, 5'd6, 32'd3, 1'b1, 2'b11, 4'b0100);
        push(32'd103, 32'd0, 5'd6, 4'b0100);
        step();
        set_in(5'd1, 32'h100, 5'd5, 32'd0, 5'd0, 32'd8, 1'b1, 2'b00, 4'b0010);
        push(32'h108, 32'd100, 5'd0, 4'b0010);
        step();
        memwb(5'd0, 1'b0, 32'd0);
        nop();
        step();

        // EX/MEM wins over MEM/WB
        rtype(5'd1, 32'd5, 5'd2, 32'd7, 5'd7, 6'h20);
        push(32'd12, 32'd7, 5'd7, 4'b0100);
        step();
        memwb(5'd7, 1'b1, 32'd999);
        rtype(5'd7, 32'd0, 5'd0, 32'd0, 5'd8, 6'h22);
        push(32'd12, 32'd0, 5'd8, 4'b0100);
        step();
        memwb(5'd0, 1'b0, 32'd0);

        // Register 0 never forwards from either stage
        rtype(5'd1, 32'd5, 5'd2, 32'd7, 5'd0, 6'h20);
        push(32'd12, 32'd7, 5'd0, 4'b0100);
        step();
        memwb(5'd0, 1'b1, 32'd55);
        rtype(5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 6'h20);
        push(32'd0, 32'd0, 5'd9, 4'b0100);
        step();
        memwb(5'd0, 1'b0, 32'd0);
        nop();
        step();

        alu_vec(2'b00, 6'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_vec(2'b01, 6'h00, 32'd3, 32'd5, 32'hFFFF_FFFE);
        alu_vec(2'b11, 6'h00, 32'hF0, 32'h0F, 32'hFF);
        alu_vec(2'b10, 6'h24, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
        alu_vec(2'b10, 6'h25, 32'h1200, 32'h0034, 32'h1234);
        alu_vec(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_vec(2'b10, 6'h2A, 32'd5, 32'hFFFF_FFFD, 32'd0);
        alu_vec(2'b10, 6'h3F, 32'd9, 32'd4, 32'd0);
        alu_vec(2'b10, 6'h22, 32'd0, 32'd1, 32'hFFFF_FFFF);
        nop();
        step();

`ifdef MUL_EN
        mul_run(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, sc);
        check("mul_stall_cycles", sc, 32 / BPC + 1);
        mul_run(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, sc);
        check("mul2_stall_cycles", sc, 32 / BPC + 1);
        mul_run(32'd7, 32'd9, 32'd63, 1'b0, sc);
        check("mul3_stall_cycles", sc, 32 / BPC + 1);

        // Flush on the fifth busy cycle aborts the multiply
        rtype(5'd14, 32'd2, 5'd15, 32'd3, 5'd16, 6'h18);
        for (int c = 0; c < 5; c++) step();
        flush_i = 1'b1;
        #1;
        check("stall_in_flush_cycle", {31'd0, stall_o}, 32'd1);
        step();
        flush_i = 1'b0;
        nop();
        #1;
        check("stall_after_flush", {31'd0, stall_o}, 32'd0);
        check("flush_no_writeback", {31'd0, RegWrite_o}, 32'd0);
        rtype(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 6'h20);
        push(32'd12, 32'd7, 5'd3, 4'b0100);
        step();
        nop();
        step();
        step();
`else
        rtype(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 6'h20);
        push(32'd12, 32'd7, 5'd3, 4'b0100);
        step();
        rtype(5'd1, 32'd5, 5'd2, 32'd7, 5'd17, 6'h18);
        #1;
        check("nomul_stall", {31'd0, stall_o}, 32'd0);
        step();
        check("nomul_regwrite", {31'd0, RegWrite_o}, 32'd0);
        check("nomul_result", ALUResult_o, 32'd0);
        nop();
        step();
        step();
`endif

        step();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage_mul.md
Name: ex_stage_mul

Overview:
- Execute stage plus EX/MEM pipeline register of the 5-stage core; consumes everything the ID/EX register produces.
- Contains the forwarding muxes, a single-cycle ALU and an iterative shift-add multiplier.
- A multiply stalls the upstream stages until its product is written into EX/MEM.
- Outputs feed the data-memory stage directly.

Parameters:
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1, 2, 4, 8; iteration count N = 32 / MUL_BITS_PER_CYCLE.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active low
flush_i  in  1  synchronous kill of the instruction currently in EX
RSdata_i, RTdata_i  in  32 each  register operands from ID/EX
RSaddr_i, RTaddr_i, RDaddr_i  in  5 each  source/destination register numbers from ID/EX
immed_i  in  32  sign-extended immediate; immed_i[5:0] is funct for R-type
ALUSrc_i, MemToReg_i, RegWrite_i, MemWrite_i, MemRead_i  in  1 each  control from ID/EX
ALUOp_i  in  2  control from ID/EX
MEMWB_RDaddr_i  in  5  MEM/WB destination register
MEMWB_RegWrite_i  in  1  MEM/WB write enable
MEMWB_data_i  in  32  MEM/WB writeback value
stall_o  out  1  freeze PC, IF/ID and ID/EX this cycle
ALUResult_o  out  32  EX/MEM result
RTdata_o  out  32  EX/MEM store data (forwarded RT)
RDaddr_o  out  5  EX/MEM destination
MemToReg_o, RegWrite_o, MemWrite_o, MemRead_o  out  1 each  EX/MEM control

Behaviour:
Reset:
- Clock is clk_i; rst_i is asynchronous and active low.
- On reset, all EX/MEM outputs are 0, the FSM goes to IDLE, the iteration counter clears and stall_o is 0.
- Reset mid-multiply aborts the multiply with no writeback.

Forwarding (combinational, per operand):
- Take the EX/MEM value (ALUResult_o) if RegWrite_o=1, RDaddr_o != 0 and RDaddr_o equals the source register.
- Otherwise take MEMWB_data_i if MEMWB_RegWrite_i=1, MEMWB_RDaddr_i != 0 and it matches.
- Otherwise take the register-file value.
- EX/MEM has priority over MEM/WB. Register 0 never forwards.
- Operand B = immed_i if ALUSrc_i=1, else forwarded RT.

ALUOp decoding:
- 00: add.
- 01: sub.
- 11: or.
- 10: use funct. 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed), 0x18 mul.
- Any other funct gives result 0.
- Arithmetic wraps modulo 2^32; no overflow trap.

FSM (IDLE, BUSY, DONE):
- IDLE, non-mul instruction: EX/MEM captures the ALU result and control at the next edge (1-cycle latency).
- IDLE, mul:
  - stall_o=1.
  - Latch forwarded A/B and RDaddr/control; clear accumulator; counter=N; go to BUSY.
  - EX/MEM captures a bubble: RegWrite, MemWrite, MemRead, MemToReg = 0.
- BUSY:
  - stall_o=1; bubble into EX/MEM.
  - Each cycle, add the B-partial-product for the low MUL_BITS_PER_CYCLE bits of the multiplier, shift, and decrement the counter.
  - Counter reaches 0 → DONE.
- DONE:
  - stall_o=0.
  - EX/MEM captures the low 32 bits of the product with the latched RDaddr and control.
  - Go to IDLE.
- Total stall = N+1 cycles. Product is written at the edge ending cycle N+1 after presentation.
- Upstream holds ID/EX constant while stall_o=1. The FSM ignores the held mul inputs in BUSY/DONE and does not restart.
- Operands are sampled only in the start cycle. Later forwarding changes do not affect the product.

flush_i:
- Flush has priority over everything.
- It forces a bubble into EX/MEM and sends the FSM to IDLE.
- Flush in the start cycle means no multiply starts.
- Flush during BUSY/DONE aborts the multiply and drops stall_o next cycle.

Optional Feature:
MUL_EN
- Defined: multiplier and FSM present, as above.
- Undefined: funct 0x18 decodes as illegal. Result is 0, RegWrite forced to 0 for that instruction, stall_o tied to 0, no FSM or multiplier logic.

Test Plan:
1. Reset low mid-run → all outputs 0 immediately; after release, add R1=5, R2=7 (ALUOp 10, funct 0x20) → ALUResult_o=12 one edge later, RegWrite_o=1.
2. Back-to-back add to $3, then sub $4=$3-$1 with $3 stale 0 in the register file and $1=5 → EX/MEM forward gives 7; MEM/WB-only match takes MEMWB_data_i; rd=0 never forwards.
3. mul 0xFFFF_FFFF × 3, MUL_BITS_PER_CYCLE=1 → stall_o high exactly 33 cycles; bubbles in EX/MEM meanwhile; then ALUResult_o=0xFFFF_FFFD, RegWrite_o=1, one writeback only.
4. Repeat test 3 with MUL_BITS_PER_CYCLE=4 → stall 9 cycles, same product; 0x0001_0000 × 0x0001_0000 → 0.
5. flush_i pulsed on BUSY cycle 5 → no writeback, stall_o low next cycle, following add executes normally.
6. Build without MUL_EN, issue mul → RegWrite_o=0, ALUResult_o=0, stall_o never asserted.
